// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage / writeback ports and the hazard controller.
// The master side is the pipeline and the slave side is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int NREG = 32,
    parameter int RW   = 5
);
    logic            ID_valid;
    logic [RW-1:0]   ID_rs1, ID_rs2, ID_rd;
    logic            ID_rs1_en, ID_rs2_en, ID_rd_wr;
    logic            ID_is_load, ID_is_mdu, ID_is_fence;
    logic            EX_redirect;
    logic            ld_wb_valid;
    logic [RW-1:0]   ld_wb_rd;
    logic            mdu_busy, mdu_done;
    logic [RW-1:0]   mdu_rd;
    logic            ID_stall, ID_flush, EX_flush, issue, mdu_start;
    logic [NREG-1:0] sb_pending;
    logic [31:0]     stall_cnt;

    modport master (
        output ID_valid, ID_rs1, ID_rs2, ID_rs1_en, ID_rs2_en, ID_rd, ID_rd_wr,
               ID_is_load, ID_is_mdu, ID_is_fence, EX_redirect,
               ld_wb_valid, ld_wb_rd, mdu_busy, mdu_done, mdu_rd,
        input  ID_stall, ID_flush, EX_flush, issue, mdu_start, sb_pending, stall_cnt
    );

    modport slave (
        input  ID_valid, ID_rs1, ID_rs2, ID_rs1_en, ID_rs2_en, ID_rd, ID_rd_wr,
               ID_is_load, ID_is_mdu, ID_is_fence, EX_redirect,
               ld_wb_valid, ld_wb_rd, mdu_busy, mdu_done, mdu_rd,
        output ID_stall, ID_flush, EX_flush, issue, mdu_start, sb_pending, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: long-latency scoreboard, MDU structural
// hazard, fence drain FSM and redirect/stall priority, all with zero-latency outputs.
module pipe_hazard_ctrl #(
    parameter int NREG = 32,
    parameter int RW   = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    pipe_hazard_ctrl_if.slave   bus
);
    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q;
    logic [NREG-1:0] pend_q, pend_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [NREG-1:0] clr, live, set;
    logic            data_hz, waw_hz, struct_hz;
    logic            drain_enter, drain_exit, stall;
    logic            stall_o, idf_o, exf_o, issue_o;

    // Same-cycle writebacks are forwarded, so cleared entries never cause a hazard.
    always_comb begin
        clr = '0;
        if (bus.ld_wb_valid) clr[bus.ld_wb_rd] = 1'b1;
        if (bus.mdu_done)    clr[bus.mdu_rd]   = 1'b1;
        live = pend_q & ~clr;

        data_hz   = (bus.ID_rs1_en && bus.ID_rs1 != '0 && live[bus.ID_rs1]) ||
                    (bus.ID_rs2_en && bus.ID_rs2 != '0 && live[bus.ID_rs2]);
        waw_hz    = bus.ID_rd_wr && bus.ID_rd != '0 && live[bus.ID_rd];
        struct_hz = bus.ID_is_mdu && bus.mdu_busy;

        drain_enter = (state_q == RUN) && bus.ID_valid && bus.ID_is_fence &&
                      !bus.EX_redirect && ((|pend_q) || bus.mdu_busy);
        drain_exit  = (state_q == DRAIN) && (live == '0) && !bus.mdu_busy;

        stall = bus.ID_valid && (data_hz || waw_hz || struct_hz || drain_enter ||
                                 ((state_q == DRAIN) && !drain_exit));

        stall_o = 1'b0;
        idf_o   = 1'b0;
        exf_o   = 1'b0;
        issue_o = 1'b0;
        if (!i_rst_n || bus.EX_redirect) begin
            idf_o = 1'b1;
            exf_o = 1'b1;
        end else if (stall) begin
            stall_o = 1'b1;
            exf_o   = 1'b1;
        end else begin
            issue_o = bus.ID_valid;
        end

        set = '0;
        if (issue_o && bus.ID_rd_wr && bus.ID_rd != '0 && (bus.ID_is_load || bus.ID_is_mdu))
            set[bus.ID_rd] = 1'b1;
        pend_d    = live | set;
        pend_d[0] = 1'b0;

        cnt_d = (stall_o && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            if (bus.EX_redirect)                      state_q <= RUN;
            else if (drain_enter)                     state_q <= DRAIN;
            else if (drain_exit)                      state_q <= RUN;
        end
    end

    assign bus.ID_stall   = stall_o;
    assign bus.ID_flush   = idf_o;
    assign bus.EX_flush   = exf_o;
    assign bus.issue      = issue_o;
    assign bus.mdu_start  = issue_o && bus.ID_is_mdu;
    assign bus.sb_pending = pend_q;
    assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus random traffic, every cycle compared against a
// rule-level model of the hazard controller.
module tb_pipe_hazard_ctrl;
    localparam int NREG = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NREG(NREG), .RW(RW)) bus ();
    pipe_hazard_ctrl #(.NREG(NREG), .RW(RW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit [NREG-1:0] m_pend = '0;
    bit            m_drain = 1'b0;
    bit [31:0]     m_cnt = '0;
    bit [NREG-1:0] n_pend;
    bit            n_drain;
    bit [31:0]     n_cnt;
    bit e_stall, e_idf, e_exf, e_iss, e_ms;

    // DUT snapshot from the last cycle
    logic s_stall, s_idf, s_exf, s_iss, s_ms;
    logic [NREG-1:0] s_pend;
    logic [31:0]     s_cnt;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit clr_at(int i);
        return (bus.ld_wb_valid && int'(bus.ld_wb_rd) == i) || (bus.mdu_done && int'(bus.mdu_rd) == i);
    endfunction

    function automatic bit busy_at(int i);
        return i != 0 && m_pend[i] && !clr_at(i);
    endfunction

    task automatic model_eval();
        bit hz, empty, enter, leave, stl;
        e_stall = 0; e_idf = 0; e_exf = 0; e_iss = 0; e_ms = 0;
        if (!rst_n) begin
            e_idf = 1; e_exf = 1;
            n_pend = '0; n_drain = 0; n_cnt = '0;
            return;
        end
        hz = (bus.ID_rs1_en && busy_at(int'(bus.ID_rs1))) ||
             (bus.ID_rs2_en && busy_at(int'(bus.ID_rs2))) ||
             (bus.ID_rd_wr  && busy_at(int'(bus.ID_rd)))  ||
             (bus.ID_is_mdu && bus.mdu_busy);
        empty = 1;
        for (int i = 0; i < NREG; i++) if (m_pend[i] && !clr_at(i)) empty = 0;
        enter = !m_drain && bus.ID_valid && bus.ID_is_fence && !bus.EX_redirect &&
                (m_pend != 0 || bus.mdu_busy);
        leave = m_drain && empty && !bus.mdu_busy;
        stl = bus.ID_valid && (hz || enter || (m_drain && !leave));
        if (bus.EX_redirect) begin
            e_idf = 1; e_exf = 1;
        end else if (stl) begin
            e_stall = 1; e_exf = 1;
        end else begin
            e_iss = bus.ID_valid;
        end
        e_ms = e_iss && bus.ID_is_mdu;
        n_drain = bus.EX_redirect ? 1'b0 : enter ? 1'b1 : leave ? 1'b0 : m_drain;
        n_pend = m_pend;
        for (int i = 0; i < NREG; i++) if (clr_at(i)) n_pend[i] = 0;
        if (e_iss && bus.ID_rd_wr && bus.ID_rd != 0 && (bus.ID_is_load || bus.ID_is_mdu))
            n_pend[bus.ID_rd] = 1;
        n_cnt = (e_stall && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_eval();
        s_stall = bus.ID_stall; s_idf = bus.ID_flush; s_exf = bus.EX_flush;
        s_iss = bus.issue; s_ms = bus.mdu_start; s_pend = bus.sb_pending; s_cnt = bus.stall_cnt;
        chk("m_stall", s_stall, e_stall);
        chk("m_idflush", s_idf, e_idf);
        chk("m_exflush", s_exf, e_exf);
        chk("m_issue", s_iss, e_iss);
        chk("m_mdustart", s_ms, e_ms);
        chk("m_pending", s_pend, m_pend);
        chk("m_stallcnt", s_cnt, m_cnt);
        @(posedge clk);
        #1;
        m_pend = n_pend; m_drain = n_drain; m_cnt = n_cnt;
    endtask

    task automatic idle();
        bus.ID_valid = 0; bus.ID_rs1 = 0; bus.ID_rs2 = 0; bus.ID_rd = 0;
        bus.ID_rs1_en = 0; bus.ID_rs2_en = 0; bus.ID_rd_wr = 0;
        bus.ID_is_load = 0; bus.ID_is_mdu = 0; bus.ID_is_fence = 0;
        bus.EX_redirect = 0; bus.ld_wb_valid = 0; bus.ld_wb_rd = 0;
        bus.mdu_busy = 0; bus.mdu_done = 0; bus.mdu_rd = 0;
    endtask

    // kind: 0 alu, 1 load, 2 mdu, 3 fence
    task automatic ins(int kind, int rd, int rs1, int rs2);
        bus.ID_valid = 1;
        bus.ID_rd = RW'(rd); bus.ID_rs1 = RW'(rs1); bus.ID_rs2 = RW'(rs2);
        bus.ID_rs1_en = (kind != 3); bus.ID_rs2_en = (kind != 3); bus.ID_rd_wr = (kind != 3);
        bus.ID_is_load = (kind == 1); bus.ID_is_mdu = (kind == 2); bus.ID_is_fence = (kind == 3);
    endtask

    initial begin
        int n;
        int k;
        rst_n = 0;
        idle();
        ins(2, 3, 1, 2);
        bus.EX_redirect = 1;
        cyc();
        chk("rst_idflush", s_idf, 1); chk("rst_exflush", s_exf, 1);
        chk("rst_stall", s_stall, 0); chk("rst_issue", s_iss, 0); chk("rst_mdustart", s_ms, 0);
        idle();
        cyc();
        rst_n = 1;
        cyc();
        chk("rst_pend", s_pend, 0); chk("rst_cnt", s_cnt, 0);

        // load-use: two stall cycles, forwarded on writeback
        ins(1, 5, 0, 0); cyc(); chk("lu_ld_issue", s_iss, 1);
        ins(0, 6, 5, 0); cyc(); chk("lu_stall1", s_stall, 1); chk("lu_exf1", s_exf, 1);
        cyc(); chk("lu_stall2", s_stall, 1);
        bus.ld_wb_valid = 1; bus.ld_wb_rd = 5;
        cyc(); chk("lu_issue", s_iss, 1); chk("lu_nostall", s_stall, 0);
        idle(); cyc(); chk("lu_cnt", s_cnt, 2);

        // x0 never tracked
        ins(1, 0, 0, 0); cyc();
        ins(0, 7, 0, 0); cyc(); chk("x0_stall", s_stall, 0); chk("x0_pend", s_pend, 0);

        // MDU busy for 4 cycles
        bus.mdu_busy = 1; ins(2, 8, 0, 0); n = 0;
        repeat (4) begin cyc(); if (s_stall) n++; end
        chk("mdu_stalls", n, 4);
        bus.mdu_busy = 0; cyc(); chk("mdu_issue", s_iss, 1); chk("mdu_start", s_ms, 1);
        idle(); bus.mdu_done = 1; bus.mdu_rd = 8; cyc(); chk("mdu_once", s_ms, 0);
        idle(); cyc(); chk("mdu_cleared", s_pend, 0);

        // redirect over data hazard and over drain
        ins(1, 4, 0, 0); cyc();
        ins(0, 9, 4, 0); cyc(); chk("rd_stall", s_stall, 1);
        bus.EX_redirect = 1; cyc();
        chk("rd_idf", s_idf, 1); chk("rd_exf", s_exf, 1); chk("rd_nostall", s_stall, 0); chk("rd_noiss", s_iss, 0);
        bus.EX_redirect = 0; ins(3, 0, 0, 0); cyc(); chk("rd_fence_enter", s_stall, 1);
        cyc(); chk("rd_fence_drain", s_stall, 1);
        bus.EX_redirect = 1; cyc(); chk("rd_drain_idf", s_idf, 1); chk("rd_drain_stall", s_stall, 0);
        bus.EX_redirect = 0; ins(0, 10, 0, 0); cyc(); chk("rd_run_issue", s_iss, 1);
        idle(); bus.ld_wb_valid = 1; bus.ld_wb_rd = 4; cyc(); idle();

        // fence drains x3 and x7, last clear at +5
        ins(1, 3, 0, 0); cyc();
        ins(1, 7, 0, 0); cyc();
        ins(3, 0, 0, 0); n = 0;
        for (int t = 0; t <= 5; t++) begin
            bus.ld_wb_valid = (t == 2 || t == 5);
            bus.ld_wb_rd = (t == 2) ? 5'd3 : 5'd7;
            cyc();
            if (s_stall) n++;
            if (t == 5) chk("fence_issue", s_iss, 1);
        end
        chk("fence_stalls", n, 5);
        idle(); ins(0, 11, 3, 7); cyc(); chk("fence_run", s_iss, 1);

        // same-cycle set and clear of x9
        ins(1, 9, 0, 0); bus.ld_wb_valid = 1; bus.ld_wb_rd = 9; cyc();
        idle(); cyc(); chk("sc_pend9", s_pend[9], 1);
        bus.ld_wb_valid = 1; bus.ld_wb_rd = 9; cyc(); idle();

        // fill scoreboard then reset
        for (int i = 1; i < NREG; i++) begin ins(1, i, 0, 0); cyc(); end
        idle(); cyc(); chk("fill_pend", s_pend, 32'hFFFF_FFFE);
        rst_n = 0; ins(0, 1, 1, 2); cyc();
        chk("frst_idf", s_idf, 1); chk("frst_exf", s_exf, 1); chk("frst_stall", s_stall, 0); chk("frst_iss", s_iss, 0);
        rst_n = 1; ins(3, 0, 0, 0); cyc();
        chk("frst_pend", s_pend, 0); chk("frst_fence_nostall", s_stall, 0); chk("frst_fence_iss", s_iss, 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst_n = ($urandom_range(0, 199) != 0);
            k = $urandom_range(0, 7);
            ins(k < 4 ? 0 : k < 6 ? 1 : k == 6 ? 2 : 3,
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            bus.ID_valid  = ($urandom_range(0, 3) != 0);
            if (k != 7) begin
                bus.ID_rs1_en = $urandom_range(0, 1);
                bus.ID_rs2_en = $urandom_range(0, 1);
                bus.ID_rd_wr  = ($urandom_range(0, 3) != 0);
            end
            bus.EX_redirect = ($urandom_range(0, 15) == 0);
            bus.ld_wb_valid = ($urandom_range(0, 2) == 0);
            bus.ld_wb_rd    = RW'($urandom_range(0, 7));
            bus.mdu_busy    = ($urandom_range(0, 2) == 0);
            bus.mdu_done    = ($urandom_range(0, 3) == 0);
            bus.mdu_rd      = RW'($urandom_range(0, 7));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
